// File: rtl/clap_light_pkg.sv
// rtl/clap_light_pkg.sv - shared state encoding and brightness table for clap_light_control
package clap_light_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_FADE   = 2'd2
  } state_t;

  localparam int NUM_LEVELS = 4;

  // Duty for brightness level k: the top of the k-th quarter of the PWM range.
  function automatic logic [31:0] level_duty(input logic [1:0] level, input int pwm_width);
    return ((32'(level) + 32'd1) << (pwm_width - 2)) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - free-running PWM comparing a wrapping counter against duty
module pwm_generator #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic [PWM_WIDTH-1:0] duty,
  output logic                 light_out
);

  logic [PWM_WIDTH-1:0] pwm_count;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      pwm_count <= '0;
      light_out <= 1'b0;
    end else begin
      pwm_count <= pwm_count + PWM_WIDTH'(1);
      light_out <= (pwm_count < duty);
    end
  end

endmodule

// File: rtl/clap_light_control.sv
// rtl/clap_light_control.sv - decodes clap counts into on/off and brightness commands, fades duty, drives PWM
module clap_light_control
  import clap_light_pkg::*;
#(
  parameter int CLAPS_WIDTH  = 16,
  parameter int PWM_WIDTH    = 8,
  parameter int TOGGLE_CLAPS = 2,
  parameter int CYCLE_CLAPS  = 3,
  parameter int FADE_DIVIDE  = 4096
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic [CLAPS_WIDTH-1:0] claps_in_data,
  input  logic                   claps_in_valid,
  output logic                   claps_in_ready,
  output logic                   light_out,
  output logic                   light_on,
  output logic [1:0]             level_out,
  output logic [PWM_WIDTH-1:0]   duty_out
);

  localparam int DIV_W = (FADE_DIVIDE > 1) ? $clog2(FADE_DIVIDE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIVIDE - 1);

  state_t                 state_q, state_d;
  logic [CLAPS_WIDTH-1:0] claps_q, claps_d;
  logic [PWM_WIDTH-1:0]   target_q, target_d;
  logic [PWM_WIDTH-1:0]   duty_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   light_on_d;
  logic [1:0]             level_d;
  logic                   ready_d;
  logic                   transfer;

  assign transfer = claps_in_valid && claps_in_ready;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q        <= ST_IDLE;
      claps_q        <= '0;
      target_q       <= '0;
      duty_out       <= '0;
      div_q          <= '0;
      light_on       <= 1'b0;
      level_out      <= 2'd0;
      claps_in_ready <= 1'b0;
    end else begin
      state_q        <= state_d;
      claps_q        <= claps_d;
      target_q       <= target_d;
      duty_out       <= duty_d;
      div_q          <= div_d;
      light_on       <= light_on_d;
      level_out      <= level_d;
      claps_in_ready <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    claps_d    = claps_q;
    target_d   = target_q;
    duty_d     = duty_out;
    div_d      = div_q;
    light_on_d = light_on;
    level_d    = level_out;
    // Ready only re-opens once a full idle cycle has been seen, and closes on a transfer.
    ready_d    = (state_q == ST_IDLE) && !transfer;

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          claps_d = claps_in_data;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (claps_q == CLAPS_WIDTH'(TOGGLE_CLAPS)) begin
          light_on_d = !light_on;
          target_d   = light_on_d ? PWM_WIDTH'(level_duty(level_out, PWM_WIDTH)) : '0;
        end else if (claps_q == CLAPS_WIDTH'(CYCLE_CLAPS) && light_on) begin
          level_d  = 2'((32'(level_out) + 32'd1) % NUM_LEVELS);
          target_d = PWM_WIDTH'(level_duty(level_d, PWM_WIDTH));
        end
        div_d   = '0;
        state_d = (target_d != duty_out) ? ST_FADE : ST_IDLE;
      end

      ST_FADE: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (duty_out < target_q) begin
            duty_d = duty_out + PWM_WIDTH'(1);
          end else if (duty_out > target_q) begin
            duty_d = duty_out - PWM_WIDTH'(1);
          end
          if (duty_d == target_q) begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  pwm_generator #(
    .PWM_WIDTH(PWM_WIDTH)
  ) u_pwm (
    .clock    (clock),
    .nreset   (nreset),
    .duty     (duty_out),
    .light_out(light_out)
  );

endmodule
